// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only target: decodes 16-bit frames (W, addr[6:0], data[7:0])
// into a five-register control bank. All outputs are registered in the clk domain.
module spi_reg_peripheral #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic [6:0] wr_addr
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   copi_dly_q, copi_dly_d;
   logic                   ncs_dly_q, ncs_dly_d;
   logic                   sclk_rise_q, sclk_rise_d;
   logic                   ncs_rise_q, ncs_rise_d;
   logic                   ncs_fall_q, ncs_fall_d;
   logic                   armed_q, armed_d;
   logic [15:0]            shift_q, shift_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [7:0]             regs_q [5];
   logic [7:0]             regs_d [5];
   logic                   wr_strobe_q, wr_strobe_d;
   logic [6:0]             wr_addr_q, wr_addr_d;
   logic                   sclk_s, ncs_s, copi_s;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign copi_s = copi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_d  = sclk_s;
      copi_dly_d  = copi_s;
      ncs_dly_d   = ncs_s;
      sclk_rise_d = sclk_s & ~sclk_dly_q;
      ncs_rise_d  = ncs_s & ~ncs_dly_q;
      // A falling ncs only counts once ncs has been genuinely sampled high since
      // reset, so ncs held low through reset release never opens a frame.
      armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ncs_s);
      ncs_fall_d  = ~ncs_s & ncs_dly_q & armed_q;
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      regs_d      = regs_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;

      case (state_q)
         IDLE: begin
            if (ncs_fall_q) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ncs_rise_q) begin
               state_d = COMMIT;
            end else if (sclk_rise_q) begin
               shift_d = {shift_q[14:0], copi_dly_q};
               if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (cnt_q == 5'd16 && shift_q[15] && 32'(shift_q[14:8]) <= MAX_ADDR) begin
               wr_strobe_d = 1'b1;
               wr_addr_d   = shift_q[14:8];
               for (int unsigned i = 0; i < 5; i++) begin
                  if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         ncs_sync_q  <= '1;
         fill_q      <= '0;
         sclk_dly_q  <= 1'b0;
         copi_dly_q  <= 1'b0;
         ncs_dly_q   <= 1'b1;
         sclk_rise_q <= 1'b0;
         ncs_rise_q  <= 1'b0;
         ncs_fall_q  <= 1'b0;
         armed_q     <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         for (int unsigned i = 0; i < 5; i++) regs_q[i] <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         fill_q      <= fill_d;
         sclk_dly_q  <= sclk_dly_d;
         copi_dly_q  <= copi_dly_d;
         ncs_dly_q   <= ncs_dly_d;
         sclk_rise_q <= sclk_rise_d;
         ncs_rise_q  <= ncs_rise_d;
         ncs_fall_q  <= ncs_fall_d;
         armed_q     <= armed_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];
   assign wr_strobe       = wr_strobe_q;
   assign wr_addr         = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: directed frames from the test plan
// plus randomized frames compared against a register-bank reference model.
module tb_spi_reg_peripheral;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe;
   logic [6:0] wr_addr;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         strobe_cnt = 0;
   int         exp_strobes = 0;
   logic [7:0] m_regs [5];
   logic [6:0] exp_addr;

   spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) strobe_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_reg0"}, 32'(en_reg_out_7_0),  32'(m_regs[0]));
      check({tag, "_reg1"}, 32'(en_reg_out_15_8), 32'(m_regs[1]));
      check({tag, "_reg2"}, 32'(en_reg_pwm_7_0),  32'(m_regs[2]));
      check({tag, "_reg3"}, 32'(en_reg_pwm_15_8), 32'(m_regs[3]));
      check({tag, "_reg4"}, 32'(pwm_duty_cycle),  32'(m_regs[4]));
      check({tag, "_strobes"}, 32'(strobe_cnt), 32'(exp_strobes));
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
      exp_addr = 7'd0;
   endtask

   // Only an exact 16-bit write frame to an address within the bank commits.
   task automatic model_frame(input logic [16:0] v, input int nbits);
      int a;
      a = int'(v[14:8]);
      if (nbits == 16 && v[15] == 1'b1 && a <= 4) begin
         m_regs[a] = v[7:0];
         exp_strobes++;
         exp_addr = v[14:8];
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [16:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi = v[i];
         wait_clk(4);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [16:0] v, input int nbits);
      ncs = 1'b0;
      wait_clk(4);
      spi_bits(v, nbits);
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(10);
      model_frame(v, nbits);
   endtask

   initial begin
      int lat;
      int nb;
      logic [16:0] v;

      rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      model_reset();
      wait_clk(3);
      check_all("reset");
      check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
      rst = 1'b0;
      wait_clk(5);

      // First write with latency measured from the raw ncs rise
      ncs = 1'b0;
      wait_clk(4);
      spi_bits(17'h080F0, 16);
      wait_clk(4);
      ncs = 1'b1;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (en_reg_out_7_0 == 8'hF0) begin
            lat = i;
            break;
         end
      end
      check("write_latency", 32'(lat), 32'd5);
      wait_clk(10);
      model_frame(17'h080F0, 16);
      check_all("first_write");

      send_frame(17'h08480, 16);
      send_frame(17'h082FF, 16);
      send_frame(17'h08440, 16);
      check_all("three_writes");

      send_frame(17'h001AA, 16);
      send_frame(17'h08555, 16);
      check_all("read_and_oob");

      v = 17'h0833C;
      send_frame(v >> 1, 15);
      send_frame({v[15:0], 1'b1}, 17);
      check_all("short_long");
      send_frame(17'h0833C, 16);
      check_all("after_short_long");

      // Mid-frame reset with all registers preloaded
      for (int i = 0; i < 5; i++) send_frame(17'h08000 | 17'(i << 8) | 17'h000A5, 16);
      check_all("preload");
      ncs = 1'b0;
      wait_clk(4);
      spi_bits(17'h00083, 8);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      wait_clk(2);
      rst = 1'b0;
      spi_bits(17'h0003C, 8);
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(10);
      check_all("post_reset_tail");

      // ncs held low across reset release
      ncs = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      wait_clk(10);
      spi_bits(17'h08155, 16);
      wait_clk(4);
      ncs = 1'b1;
      wait_clk(10);
      check_all("ncs_low_at_release");
      send_frame(17'h08177, 16);
      check_all("after_ncs_low");

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 4))
            0:       nb = 15;
            1:       nb = 17;
            default: nb = 16;
         endcase
         v = 17'($urandom);
         v[14:8] = 7'($urandom_range(0, 7));
         if (nb == 16) v[15] = ($urandom_range(0, 3) != 0);
         send_frame(v, nb);
         check_all("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
